// File: rtl/regfile_mp.sv
// regfile_mp: 2-read / 2-write register file with a sequential clear engine.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              busy,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clrIdx_q, clrIdx_d;
  logic [DATA_W-1:0] regs_q [DEPTH];

  logic              busyInt;
  logic              wrOk0, wrOk1;
  logic [ADDR_W-1:0] rAddr [2];
  logic [DATA_W-1:0] rData [2];

  assign busyInt = (state_q == CLEAR);
  assign busy    = busyInt;

  // A write is effective only in IDLE, out of reset, and never to a hardwired zero register
  assign wrOk0 = we0 && !reset && !busyInt && !((ZERO_REG != 0) && (waddr0 == '0));
  assign wrOk1 = we1 && !reset && !busyInt && !((ZERO_REG != 0) && (waddr1 == '0));

  always_comb begin
    state_d  = state_q;
    clrIdx_d = clrIdx_q;
    if (reset) begin
      state_d  = CLEAR;
      clrIdx_d = '0;
    end else begin
      case (state_q)
        CLEAR: begin
          clrIdx_d = clrIdx_q + 1'b1;
          if (clrIdx_q == {ADDR_W{1'b1}}) begin
            state_d = IDLE;
          end
        end
        default: begin
          if (clear_req) begin
            state_d  = CLEAR;
            clrIdx_d = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q  <= state_d;
    clrIdx_q <= clrIdx_d;
  end

  // Port 1 is written last so it wins an address conflict with port 0
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busyInt) begin
        regs_q[clrIdx_q] <= '0;
      end else begin
        if (wrOk0) begin
          regs_q[waddr0] <= wdata0;
        end
        if (wrOk1) begin
          regs_q[waddr1] <= wdata1;
        end
      end
    end
  end

  assign rAddr[0] = raddr_a;
  assign rAddr[1] = raddr_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rData[p] = regs_q[rAddr[p]];
`ifdef REGFILE_MP_BYPASS_EN
      if (wrOk1 && (waddr1 == rAddr[p])) begin
        rData[p] = wdata1;
      end else if (wrOk0 && (waddr0 == rAddr[p])) begin
        rData[p] = wdata0;
      end
`endif
      if (busyInt || ((ZERO_REG != 0) && (rAddr[p] == '0))) begin
        rData[p] = '0;
      end
    end
  end

  assign rdata_a = rData[0];
  assign rdata_b = rData[1];

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (default parameters).
// Expected read data comes from a small array model pushed into a scoreboard queue.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          clear_req = 1'b0;
  logic          busy;
  logic          we0       = 1'b0;
  logic [AW-1:0] waddr0    = '0;
  logic [DW-1:0] wdata0    = '0;
  logic          we1       = 1'b0;
  logic [AW-1:0] waddr1    = '0;
  logic [DW-1:0] wdata1    = '0;
  logic [AW-1:0] raddr_a   = '0;
  logic [DW-1:0] rdata_a;
  logic [AW-1:0] raddr_b   = '0;
  logic [DW-1:0] rdata_b;

  int            assertCount = 0;
  int            failCount   = 0;
  logic [31:0]   sbQ[$];
  logic [31:0]   model [DEPTH];
  logic          busyModel = 1'b1;
  int            n;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear_req(clear_req),
    .busy     (busy),
    .we0      (we0),
    .waddr0   (waddr0),
    .wdata0   (wdata0),
    .we1      (we1),
    .waddr1   (waddr1),
    .wdata1   (wdata1),
    .raddr_a  (raddr_a),
    .rdata_a  (rdata_a),
    .raddr_b  (raddr_b),
    .rdata_b  (rdata_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed);
    logic [31:0] expected;
    assertCount++;
    if (sbQ.size() == 0) begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=<nothing queued>", tag, observed);
    end else begin
      expected = sbQ.pop_front();
      assert (observed === expected) else begin
        failCount++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [AW-1:0] addr);
    if (busyModel || addr == '0) return 32'h0;
`ifdef REGFILE_MP_BYPASS_EN
    if (!reset && we1 && waddr1 == addr && waddr1 != '0) return wdata1;
    if (!reset && we0 && waddr0 == addr && waddr0 != '0) return wdata0;
`endif
    return model[addr];
  endfunction

  task automatic applyStimulus(input logic [AW-1:0] addrA, input logic [AW-1:0] addrB);
    raddr_a = addrA;
    raddr_b = addrB;
    sbQ.push_back(modelRead(addrA));
    sbQ.push_back(modelRead(addrB));
  endtask

  task automatic readBoth(input string tag, input logic [AW-1:0] addrA, input logic [AW-1:0] addrB);
    applyStimulus(addrA, addrB);
    #1;
    checkOutput({tag, "_a"}, rdata_a);
    checkOutput({tag, "_b"}, rdata_b);
  endtask

  task automatic checkBusy(input string tag, input logic expBusy);
    sbQ.push_back({31'b0, expBusy});
    checkOutput(tag, {31'b0, busy});
  endtask

  // Commit pending writes to the model, take one edge, then drop single-cycle inputs
  task automatic commitEdge();
    if (!busyModel && !reset) begin
      if (we0 && waddr0 != '0) model[waddr0] = wdata0;
      if (we1 && waddr1 != '0) model[waddr1] = wdata1;
    end
    step();
    we0       = 1'b0;
    we1       = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic waitIdle(output int edges);
    edges = 0;
    do begin
      step();
      edges++;
    end while (busy !== 1'b0 && edges < 100);
  endtask

  task automatic zeroModel();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  task automatic readAll(input string tag);
    for (int i = 0; i < DEPTH; i++) readBoth(tag, 5'(i), 5'(DEPTH - 1 - i));
  endtask

  task automatic writePort0(input logic [AW-1:0] a, input logic [31:0] d);
    we0    = 1'b1;
    waddr0 = a;
    wdata0 = d;
  endtask

  task automatic writePort1(input logic [AW-1:0] a, input logic [31:0] d);
    we1    = 1'b1;
    waddr1 = a;
    wdata1 = d;
  endtask

  initial begin
    zeroModel();

    // Reset for 3 cycles: busy high, reads forced to zero
    reset = 1'b1;
    repeat (3) step();
    busyModel = 1'b1;
    checkBusy("rstBusy", 1'b1);
    readBoth("rstRd", 5'd5, 5'd0);

    // Release: clear takes exactly DEPTH edges
    reset = 1'b0;
    waitIdle(n);
    sbQ.push_back(32'd32);
    checkOutput("initClearLen", n);
    busyModel = 1'b0;
    checkBusy("initIdle", 1'b0);
    readAll("initRd");

    // Basic write and zero-register write
    writePort0(5'd5, 32'hDEADBEEF);
    commitEdge();
    readBoth("wr5", 5'd5, 5'd0);
    writePort0(5'd0, 32'h0000FFFF);
    commitEdge();
    readBoth("wr0", 5'd0, 5'd5);

    // Same-address conflict: port 1 wins
    writePort0(5'd7, 32'h1111);
    writePort1(5'd7, 32'h2222);
    commitEdge();
    readBoth("conflict7", 5'd7, 5'd5);

    // Independent addresses on both ports
    writePort0(5'd12, 32'hAAAA5555);
    writePort1(5'd13, 32'h5555AAAA);
    commitEdge();
    readBoth("dual", 5'd12, 5'd13);

    // Same-cycle read of written address (forwarded only when bypass is built in)
    writePort0(5'd9, 32'hABCD);
    readBoth("byp9", 5'd5, 5'd9);
    commitEdge();
    readBoth("post9", 5'd9, 5'd9);

    writePort0(5'd20, 32'h3333);
    writePort1(5'd20, 32'h4444);
    readBoth("byp20", 5'd20, 5'd7);
    commitEdge();
    readBoth("post20", 5'd20, 5'd20);

    writePort0(5'd0, 32'h55);
    readBoth("byp0", 5'd0, 5'd0);
    commitEdge();

    // Load 1..4, then clear_req together with a write to 6
    for (int i = 1; i <= 4; i++) begin
      writePort0(5'(i), 32'h100 + 32'(i));
      commitEdge();
    end
    readBoth("ld", 5'd1, 5'd4);
    readBoth("ld2", 5'd2, 5'd3);

    writePort0(5'd6, 32'h66);
    clear_req = 1'b1;
    commitEdge();
    busyModel = 1'b1;
    zeroModel();
    checkBusy("clrBusy", 1'b1);
    readBoth("clrRd", 5'd1, 5'd4);

    // Writes and a second clear_req while busy are both dropped
    writePort0(5'd25, 32'h2525);
    writePort1(5'd2, 32'h2222);
    commitEdge();
    writePort0(5'd26, 32'h2626);
    clear_req = 1'b1;
    commitEdge();
    readBoth("clrRd2", 5'd2, 5'd25);
    waitIdle(n);
    sbQ.push_back(32'd32);
    checkOutput("reqClearLen", n + 2);
    busyModel = 1'b0;
    checkBusy("reqIdle", 1'b0);
    readAll("postClr");

    // Reset in the middle of a clear restarts the full sweep
    writePort0(5'd30, 32'h3030);
    commitEdge();
    readBoth("pre30", 5'd30, 5'd6);
    clear_req = 1'b1;
    commitEdge();
    busyModel = 1'b1;
    zeroModel();
    repeat (10) step();
    checkBusy("midClrBusy", 1'b1);
    reset = 1'b1;
    repeat (2) step();
    checkBusy("midRstBusy", 1'b1);
    readBoth("midRstRd", 5'd30, 5'd1);
    reset = 1'b0;
    waitIdle(n);
    sbQ.push_back(32'd32);
    checkOutput("rstClearLen", n);
    busyModel = 1'b0;
    checkBusy("finalIdle", 1'b0);
    readBoth("final30", 5'd30, 5'd6);

    // Array is writable again after the restarted clear
    writePort1(5'd30, 32'hCAFEF00D);
    commitEdge();
    readBoth("final", 5'd30, 5'd31);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
